// File: rtl/lcd1602_bus_responder_if.sv
// Signal bundle between the LCD bus (plus shadow read port) and the bus responder.
// err_init exists only when LCD_STRICT_INIT_EN is defined.
interface lcd1602_bus_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_valid;
    logic [4:0] wr_addr;
    logic [7:0] wr_char;
    logic [4:0] cursor;
    logic       display_on;
    logic       func_ok;
    logic       busy;
    logic       err_overrun;
    logic       err_read;
`ifdef LCD_STRICT_INIT_EN
    logic       err_init;

    modport master (
        output lcd_rs, lcd_rw, lcd_en, lcd_data, rd_addr,
        input  rd_data, wr_valid, wr_addr, wr_char, cursor, display_on, func_ok, busy,
               err_overrun, err_read, err_init
    );
    modport slave (
        input  lcd_rs, lcd_rw, lcd_en, lcd_data, rd_addr,
        output rd_data, wr_valid, wr_addr, wr_char, cursor, display_on, func_ok, busy,
               err_overrun, err_read, err_init
    );
`else
    modport master (
        output lcd_rs, lcd_rw, lcd_en, lcd_data, rd_addr,
        input  rd_data, wr_valid, wr_addr, wr_char, cursor, display_on, func_ok, busy,
               err_overrun, err_read
    );
    modport slave (
        input  lcd_rs, lcd_rw, lcd_en, lcd_data, rd_addr,
        output rd_data, wr_valid, wr_addr, wr_char, cursor, display_on, func_ok, busy,
               err_overrun, err_read
    );
`endif
endinterface

// File: rtl/lcd1602_bus_responder.sv
// HD44780/LCD1602 8-bit bus listener keeping a 2x16 DDRAM shadow.
// Optional macro LCD_STRICT_INIT_EN: reject character writes until a valid Function Set.
module lcd1602_bus_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         MIN_EN_HIGH = 4,
    parameter logic [7:0] CLEAR_FILL  = 8'h20
) (
    input  logic                    clk,
    input  logic                    reset,
    lcd1602_bus_responder_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for a strobe
    // EXEC  | one strobe was just applied
    // CLEAR | filling 32 cells with CLEAR_FILL, strobes dropped
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_t;

    localparam int             CNT_W  = $clog2(MIN_EN_HIGH + 1);
    localparam logic [CNT_W-1:0] EN_SAT = CNT_W'(MIN_EN_HIGH);

    state_t          state, state_nxt;
    logic [10:0]     sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] en_hi_cnt;
    logic            en_d;
    logic            en_s, rw_s, rs_s;
    logic [7:0]      data_s;
    logic            strobe, clear_cmd, take, drop, fill, store, init_ok;
    logic [4:0]      clr_cnt;
    logic [7:0]      shadow [32];

    logic [4:0]      cursor;
    logic            incr;
    logic            display_on;
    logic            func_ok;
    logic            err_overrun;
    logic            err_read;
    logic            wr_valid;
    logic [4:0]      wr_addr;
    logic [7:0]      wr_char;
    logic [7:0]      rd_data;

    // en, rw, rs and data share one chain so they stay cycle-aligned
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign en_s   = sync_q[SYNC_STAGES-1][10];
    assign rw_s   = sync_q[SYNC_STAGES-1][9];
    assign rs_s   = sync_q[SYNC_STAGES-1][8];
    assign data_s = sync_q[SYNC_STAGES-1][7:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            en_hi_cnt <= '0;
            en_d      <= 1'b0;
        end else begin
            en_d <= en_s;
            if (!en_s)                 en_hi_cnt <= '0;
            else if (en_hi_cnt != EN_SAT) en_hi_cnt <= en_hi_cnt + 1'b1;
        end
    end

    assign strobe    = en_d & ~en_s & (en_hi_cnt == EN_SAT);
    assign clear_cmd = ~rw_s & ~rs_s & (data_s == 8'h01);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        drop      = 1'b0;
        fill      = 1'b0;
        case (state)
            ST_IDLE, ST_EXEC: begin
                state_nxt = ST_IDLE;
                if (strobe) begin
                    take      = 1'b1;
                    state_nxt = clear_cmd ? ST_CLEAR : ST_EXEC;
                end
            end
            ST_CLEAR: begin
                fill = 1'b1;
                drop = strobe;
                if (clr_cnt == 5'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef LCD_STRICT_INIT_EN
    logic err_init;
    assign init_ok = func_ok;
    always_ff @(posedge clk) begin
        if (!reset)                                  err_init <= 1'b0;
        else if (take && !rw_s && rs_s && !func_ok)  err_init <= 1'b1;
    end
    assign bus.err_init = err_init;
`else
    assign init_ok = 1'b1;
`endif

    assign store = take & ~rw_s & rs_s & init_ok;

    // clr_cnt counts down 31..0; the fill index is its complement so cells go 0..31
    always_ff @(posedge clk) begin
        if (reset && fill)  shadow[~clr_cnt] <= CLEAR_FILL;
        else if (store)     shadow[cursor]   <= data_s;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cursor      <= '0;
            incr        <= 1'b1;
            display_on  <= 1'b0;
            func_ok     <= 1'b0;
            err_overrun <= 1'b0;
            err_read    <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_char     <= '0;
            clr_cnt     <= 5'd31;
            rd_data     <= '0;
        end else begin
            wr_valid <= 1'b0;
            rd_data  <= shadow[bus.rd_addr];
            if (strobe && rw_s) err_read    <= 1'b1;
            if (drop)           err_overrun <= 1'b1;
            if (store) begin
                wr_valid <= 1'b1;
                wr_addr  <= cursor;
                wr_char  <= data_s;
                cursor   <= incr ? cursor + 5'd1 : cursor - 5'd1;
            end
            if (take && !rw_s && !rs_s) begin
                casez (data_s)
                    8'b1???????: begin
                        if (data_s[6:4] == 3'b000)      cursor <= {1'b0, data_s[3:0]};
                        else if (data_s[6:4] == 3'b100) cursor <= {1'b1, data_s[3:0]};
                    end
                    8'b01??????: ;
                    8'b001?????: func_ok    <= data_s[4] & data_s[3];
                    8'b0001????: ;
                    8'b00001???: display_on <= data_s[2];
                    8'b000001??: incr       <= data_s[1];
                    8'b0000001?: cursor     <= '0;
                    8'b00000001: clr_cnt    <= 5'd31;
                    default: ;
                endcase
            end
            if (fill) begin
                clr_cnt <= clr_cnt - 5'd1;
                if (clr_cnt == 5'd0) begin
                    cursor <= '0;
                    incr   <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.wr_valid    = wr_valid;
    assign bus.wr_addr     = wr_addr;
    assign bus.wr_char     = wr_char;
    assign bus.cursor      = cursor;
    assign bus.display_on  = display_on;
    assign bus.func_ok     = func_ok;
    assign bus.busy        = (state == ST_CLEAR);
    assign bus.err_overrun = err_overrun;
    assign bus.err_read    = err_read;
endmodule

// File: tb/tb_lcd1602_bus_responder.sv
// Scoreboard bench for lcd1602_bus_responder: a panel-level model predicts writes,
// cursor and flags; a monitor checks every wr_valid pulse against the expected queue.
module tb_lcd1602_bus_responder;
    localparam int SYNC = 2;
    localparam int MINH = 4;
`ifdef LCD_STRICT_INIT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lcd1602_bus_responder_if bus();

    lcd1602_bus_responder #(.SYNC_STAGES(SYNC), .MIN_EN_HIGH(MINH), .CLEAR_FILL(8'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [4:0] a; logic [7:0] c; } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int n_wr = 0;

    logic [7:0] m_mem [32];
    int m_cur = 0;
    bit m_incr = 1, m_disp = 0, m_func = 0, m_ovr = 0, m_rd = 0, m_init = 0, m_busy = 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.wr_valid) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d char %0h expected none", bus.wr_addr, bus.wr_char);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.wr_addr, e.a);
                    chk("wr_char", bus.wr_char, e.c);
                end
            end
        end
    end

    // Panel behaviour from the command set, not from the RTL structure
    task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d, input int hi, output bit is_clr);
        int a;
        wr_t w;
        is_clr = 1'b0;
        if (hi < MINH) return;
        if (m_busy) m_ovr = 1;
        if (rw) m_rd = 1;
        if (m_busy || rw) return;
        if (rs) begin
            if (STRICT && !m_func) begin
                m_init = 1;
            end else begin
                w.a = m_cur[4:0];
                w.c = d;
                exp_q.push_back(w);
                m_mem[m_cur] = d;
                m_cur = (m_cur + (m_incr ? 1 : 31)) % 32;
            end
        end else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_cur = 0;
            m_incr = 1;
            is_clr = 1'b1;
        end else if (d >= 128) begin
            a = d - 128;
            if (a < 16) m_cur = a;
            else if (a >= 64 && a < 80) m_cur = a - 48;
        end else if (d >= 64) begin
        end else if (d >= 32) begin
            m_func = d[4] & d[3];
        end else if (d >= 16) begin
        end else if (d >= 8) begin
            m_disp = d[2];
        end else if (d >= 4) begin
            m_incr = d[1];
        end else if (d >= 2) begin
            m_cur = 0;
        end
    endtask

    task automatic check_flags();
        chk("cursor", bus.cursor, m_cur);
        chk("display_on", bus.display_on, m_disp);
        chk("func_ok", bus.func_ok, m_func);
        chk("err_overrun", bus.err_overrun, m_ovr);
        chk("err_read", bus.err_read, m_rd);
`ifdef LCD_STRICT_INIT_EN
        chk("err_init", bus.err_init, m_init);
`endif
    endtask

    task automatic wait_clear(input bit count_it);
        int n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (count_it) chk("clear_cycles", n, 32);
        else          chk("busy_fall", bus.busy, 0);
        m_busy = 0;
    endtask

    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input int hi, input bit wait_clr);
        bit clr;
        model_apply(rs, rw, d, hi, clr);
        bus.lcd_rs   = rs;
        bus.lcd_rw   = rw;
        bus.lcd_data = d;
        bus.lcd_en   = 1'b1;
        repeat (hi) @(negedge clk);
        bus.lcd_en = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        if (clr) begin
            m_busy = 1;
            if (wait_clr) wait_clear(1'b1);
        end
        if (!m_busy) check_flags();
    endtask

    task automatic check_mem();
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr = i[4:0];
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", i), bus.rd_data, m_mem[i]);
        end
    endtask

    initial begin : stim
        string l1, l2;
        int wr0, kind;
        logic [7:0] d;
        bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_en = 0; bus.lcd_data = '0; bus.rd_addr = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;

        repeat (4) @(negedge clk);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_wr_valid", bus.wr_valid, 0);
        check_flags();
        reset = 1'b1;
        wait_clear(1'b1);
        check_flags();
        check_mem();

        strobe(1, 0, 8'h51, 5, 1);

        strobe(0, 0, 8'h38, 5, 1);
        strobe(0, 0, 8'h06, 5, 1);
        strobe(0, 0, 8'h0C, 5, 1);
        strobe(0, 0, 8'h01, 5, 1);

        l1 = "HELLO WORLD 1602";
        l2 = "BUS RESPONDER OK";
        wr0 = n_wr;
        for (int i = 0; i < 16; i++) strobe(1, 0, l1[i], 5, 1);
        strobe(0, 0, 8'hC0, 5, 1);
        for (int i = 0; i < 16; i++) strobe(1, 0, l2[i], 5, 1);
        chk("wr_pulses", n_wr - wr0, 32);
        check_mem();

        strobe(1, 0, 8'h41, 2, 1);
        strobe(1, 0, 8'h41, 4, 1);

        strobe(0, 0, 8'h01, 5, 0);
        strobe(1, 0, 8'h41, 4, 0);
        wait_clear(1'b0);
        check_flags();
        strobe(1, 1, 8'h41, 5, 1);
        check_mem();

        strobe(0, 0, 8'h04, 5, 1);
        strobe(0, 0, 8'h80, 5, 1);
        strobe(1, 0, 8'h5A, 5, 1);
        strobe(0, 0, 8'h06, 5, 1);

        for (int t = 0; t < 90; t++) begin
            kind = $urandom_range(0, 15);
            d = 8'($urandom_range(0, 255));
            if (kind < 8)       strobe(1, 0, d, (kind == 0) ? 2 : $urandom_range(4, 6), 1);
            else if (kind == 8) strobe(0, 0, 8'h01, 5, 1);
            else if (kind == 9) strobe(0, 0, 8'h80 | 8'($urandom_range(0, 15)) | (d & 8'h40), 5, 1);
            else if (kind == 10) strobe(0, 0, 8'h38 | (d & 8'h04), 5, 1);
            else if (kind == 11) strobe(0, 1, d, 5, 1);
            else                 strobe(0, 0, (d == 8'h01) ? 8'h02 : d, $urandom_range(3, 6), 1);
        end
        check_mem();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
